// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from the AD sample FIFO and shifts them out as
// 8N1/8N2 UART frames, LSB first. Counts bytes sent and completed frames,
// where a frame ends with the transmission of EOF_BYTE.
`timescale 1ns/1ps
module uart_fifo_tx #(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter int         STOP_BITS = 1,
    parameter logic [7:0] EOF_BYTE  = 8'h0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_q,
    output logic        fifo_rdreq,
    output logic        uart_txd,
    output logic        busy,
    output logic        byte_done,
    output logic        frame_done,
    output logic [15:0] byte_cnt,
    output logic [7:0]  frame_cnt,
    output logic [2:0]  tx_state
);

    localparam int          DIV       = CLK_FREQ / BAUD;
    localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        STOP    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        rdreq_q, rdreq_d;
    logic        busy_q, busy_d;
    logic        byte_done_q, byte_done_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        bit_end;

    // Last clock of the current bit period (start, data or stop bit).
    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // State register; reset aborts any byte in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: fetch, wait for FIFO data, then start/data/stop bits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_en && !fifo_empty) state_d = RD_REQ;
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_end && bit_idx_q == STOP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values, derived from the next state so every output is a flop.
    always_comb begin
        shift_d = shift_q;
        if (state_q == RD_WAIT) shift_d = fifo_q;

        // Bit timer restarts on every bit boundary and every state change.
        if ((state_d != state_q) || bit_end ||
            !(state_q == START || state_q == DATA || state_q == STOP))
            baud_cnt_d = 16'd0;
        else
            baud_cnt_d = baud_cnt_q + 16'd1;

        // Bit index counts data bits in DATA and stop bits in STOP.
        bit_idx_d = bit_idx_q;
        if (state_d != state_q)
            bit_idx_d = 3'd0;
        else if (bit_end && (state_q == DATA || state_q == STOP))
            bit_idx_d = bit_idx_q + 3'd1;

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bit_idx_d];
            default: txd_d = 1'b1;
        endcase

        rdreq_d      = (state_d == RD_REQ);
        busy_d       = (state_d != IDLE);
        byte_done_d  = (state_d == STOP) && (bit_idx_d == STOP_LAST) &&
                       (baud_cnt_d == BAUD_LAST);
        frame_done_d = byte_done_d && (shift_q == EOF_BYTE);
        byte_cnt_d   = byte_cnt_q + {15'd0, byte_done_d};
        frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_d};
    end

    // Datapath and registered outputs; line idles high under reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q   <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            txd_q        <= 1'b1;
            rdreq_q      <= 1'b0;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            byte_cnt_q   <= 16'd0;
            frame_cnt_q  <= 8'd0;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            txd_q        <= txd_d;
            rdreq_q      <= rdreq_d;
            busy_q       <= busy_d;
            byte_done_q  <= byte_done_d;
            frame_done_q <= frame_done_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign fifo_rdreq = rdreq_q;
    assign uart_txd   = txd_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;
    assign frame_done = frame_done_q;
    assign byte_cnt   = byte_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign tx_state   = state_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Testbench for uart_fifo_tx: queue-based FIFO model, free-running UART
// receiver and pulse monitors on instance A (8N1), direct stimulus on B (8N2).
`timescale 1ns/1ps
module tb_uart_fifo_tx;

    localparam int D = 10;   // 1 MHz / 100 kbaud

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        tx_en_a = 1'b1, fifo_empty_a = 1'b1;
    logic [7:0]  fifo_q_a = 8'h00;
    logic        rdreq_a, txd_a, busy_a, bdone_a, fdone_a;
    logic [15:0] bcnt_a;
    logic [7:0]  fcnt_a;
    logic [2:0]  st_a;

    logic        tx_en_b = 1'b1, fifo_empty_b = 1'b1;
    logic [7:0]  fifo_q_b = 8'h00;
    logic        rdreq_b, txd_b, busy_b, bdone_b, fdone_b;
    logic [15:0] bcnt_b;
    logic [7:0]  fcnt_b;
    logic [2:0]  st_b;

    int vectors = 0, miscompares = 0;

    uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en_a), .fifo_empty(fifo_empty_a),
        .fifo_q(fifo_q_a), .fifo_rdreq(rdreq_a), .uart_txd(txd_a), .busy(busy_a),
        .byte_done(bdone_a), .frame_done(fdone_a), .byte_cnt(bcnt_a),
        .frame_cnt(fcnt_a), .tx_state(st_a));

    uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en_b), .fifo_empty(fifo_empty_b),
        .fifo_q(fifo_q_b), .fifo_rdreq(rdreq_b), .uart_txd(txd_b), .busy(busy_b),
        .byte_done(bdone_b), .frame_done(fdone_b), .byte_cnt(bcnt_b),
        .frame_cnt(fcnt_b), .tx_state(st_b));

    always #5 clk = ~clk;

    // FIFO model for A: q is updated on the edge that sees rdreq.
    logic [7:0] fq[$];
    int underflow = 0;
    always @(posedge clk) begin
        if (rdreq_a) begin
            if (fq.size() > 0) fifo_q_a <= fq.pop_front();
            else underflow++;
            fifo_empty_a <= (fq.size() == 0);
        end
    end

    task automatic push_a(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty_a = 1'b0;
    endtask

    // Monitors on A: cycle count, rdreq timestamps, pulse counts, UART receiver.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdq_t[$];
    int nbd = 0, nfd = 0, fd_at = 0, coinc_err = 0;
    always @(negedge clk) begin
        if (bdone_a) nbd++;
        if (fdone_a) begin
            nfd++;
            fd_at = nbd;
            if (!bdone_a) coinc_err++;
        end
        if (rdreq_a) rdq_t.push_back(cyc);
    end

    logic [7:0] rxq[$];
    logic [7:0] rx_sh = 8'h00;
    bit rx_act = 1'b0;
    int rx_cnt = 0, rx_ferr = 0;
    always @(negedge clk) begin
        if (!reset_n) rx_act = 1'b0;
        else if (!rx_act) begin
            if (txd_a === 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
                rx_sh[(rx_cnt - 15) / 10] = txd_a;
            if (rx_cnt == 95) begin
                if (txd_a !== 1'b1) rx_ferr++;
                rxq.push_back(rx_sh);
                rx_act = 1'b0;
            end
        end
    end

    // Expected line level k clocks after the rdreq clock, from the frame format.
    function automatic logic model_txd(int k, logic [7:0] b);
        if (k < 2) return 1'b1;
        if (k < 2 + D) return 1'b0;
        if (k < 2 + 9 * D) return b[(k - 2 - D) / D];
        return 1'b1;
    endfunction

    task automatic wait_rdreq(input bit sel_b, input int limit, output int waited);
        waited = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel_b ? rdreq_b : rdreq_a) === 1'b1) begin
                waited = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (txd_a !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b expected 1", txd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy_a); end
        vectors++; if (rdreq_a !== 1'b0) begin miscompares++; $display("FAIL reset_rdreq got %b expected 0", rdreq_a); end
        vectors++; if (bcnt_a !== 16'd0) begin miscompares++; $display("FAIL reset_bcnt got %h expected 0000", bcnt_a); end
        vectors++; if (fcnt_a !== 8'd0) begin miscompares++; $display("FAIL reset_fcnt got %h expected 00", fcnt_a); end
        vectors++; if ({bdone_a, fdone_a} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses got %b expected 00", {bdone_a, fdone_a}); end
        vectors++; if (st_a !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d expected 0", st_a); end
        vectors++; if ({txd_b, busy_b, rdreq_b} !== 3'b100) begin miscompares++; $display("FAIL reset_b got %b expected 100", {txd_b, busy_b, rdreq_b}); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if ({st_a, txd_a, rdreq_a} !== 5'b00010) begin miscompares++; $display("FAIL idle_empty got %b expected 00010", {st_a, txd_a, rdreq_a}); end
    endtask

    task automatic test_single_byte;
        int w;
        logic [4:0] got, exp;
        rxq.delete();
        rdq_t.delete();
        push_a(8'h5A);
        wait_rdreq(1'b0, 20, w);
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL rdreq_latency got %0d expected 1", w); end
        if (w < 0) return;
        for (int k = 0; k < 2 + 10 * D + 2; k++) begin
            got = {txd_a, rdreq_a, busy_a, bdone_a, fdone_a};
            exp = {model_txd(k, 8'h5A), (k == 0), (k <= 2 + 10 * D - 1), (k == 2 + 10 * D - 1), 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wave_a k=%0d got txd/rdreq/busy/bdone/fdone=%b expected %b", k, got, exp);
            end
            @(negedge clk);
        end
        vectors++; if (bcnt_a !== 16'd1) begin miscompares++; $display("FAIL single_bcnt got %0d expected 1", bcnt_a); end
        vectors++; if (fcnt_a !== 8'd0) begin miscompares++; $display("FAIL single_fcnt got %0d expected 0", fcnt_a); end
        vectors++; if (rxq.size() != 1 || rxq[0] !== 8'h5A) begin miscompares++; $display("FAIL single_rx got %0d bytes expected one 5a", rxq.size()); end
    endtask

    task automatic test_frame;
        logic [7:0] sent[$];
        logic [7:0] b;
        int nbd0, nfd0, gap;
        bit done;
        rxq.delete();
        rdq_t.delete();
        nbd0 = nbd;
        nfd0 = nfd;
        for (int i = 0; i < 32; i++) begin
            b = 8'($urandom_range(0, 255));
            while (b == 8'h0A) b = 8'($urandom_range(0, 255));
            sent.push_back(b);
        end
        sent.push_back(8'hCC);
        sent.push_back(8'h0D);
        sent.push_back(8'h0A);
        foreach (sent[i]) push_a(sent[i]);
        done = 1'b0;
        for (int i = 0; i < 36 * 103 + 100; i++) begin
            @(negedge clk);
            if (rdq_t.size() >= 35 && !busy_a) begin done = 1'b1; break; end
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL frame_timeout got %0d rdreqs expected 35", rdq_t.size()); end
        vectors++; if (rdq_t.size() != 35) begin miscompares++; $display("FAIL frame_rdreqs got %0d expected 35", rdq_t.size()); end
        for (int i = 1; i < rdq_t.size(); i++) begin
            gap = rdq_t[i] - rdq_t[i - 1];
            vectors++; if (gap != 103) begin miscompares++; $display("FAIL frame_gap i=%0d got %0d expected 103", i, gap); end
        end
        vectors++; if (rxq.size() != 35) begin miscompares++; $display("FAIL frame_rxcount got %0d expected 35", rxq.size()); end
        for (int i = 0; i < 35 && i < rxq.size(); i++) begin
            vectors++; if (rxq[i] !== sent[i]) begin miscompares++; $display("FAIL frame_data i=%0d got %h expected %h", i, rxq[i], sent[i]); end
        end
        vectors++; if (nfd - nfd0 != 1) begin miscompares++; $display("FAIL frame_pulses got %0d expected 1", nfd - nfd0); end
        vectors++; if (fd_at - nbd0 != 35) begin miscompares++; $display("FAIL frame_pos got byte %0d expected 35", fd_at - nbd0); end
        vectors++; if (nbd - nbd0 != 35) begin miscompares++; $display("FAIL frame_bdone got %0d expected 35", nbd - nbd0); end
        vectors++; if (bcnt_a !== 16'd36) begin miscompares++; $display("FAIL frame_bcnt got %0d expected 36", bcnt_a); end
        vectors++; if (fcnt_a !== 8'd1) begin miscompares++; $display("FAIL frame_fcnt got %0d expected 1", fcnt_a); end
    endtask

    task automatic test_tx_en;
        int w, n0;
        rxq.delete();
        rdq_t.delete();
        tx_en_a = 1'b0;
        @(negedge clk);
        push_a(8'h81);
        push_a(8'h2C);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++; if ({txd_a, rdreq_a, busy_a} !== 3'b100) begin miscompares++; $display("FAIL txen_off i=%0d got %b expected 100", i, {txd_a, rdreq_a, busy_a}); end
        end
        tx_en_a = 1'b1;
        wait_rdreq(1'b0, 5, w);
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL txen_fetch got %0d expected 1", w); end
        for (int i = 0; i < 30; i++) begin
            if (st_a === 3'd4) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        tx_en_a = 1'b0;
        n0 = nbd;
        repeat (120) @(negedge clk);
        vectors++; if (rdq_t.size() != 1) begin miscompares++; $display("FAIL txen_rdreqs got %0d expected 1", rdq_t.size()); end
        vectors++; if (rxq.size() != 1 || rxq[0] !== 8'h81) begin miscompares++; $display("FAIL txen_rx got %0d bytes expected one 81", rxq.size()); end
        vectors++; if (nbd - n0 != 1) begin miscompares++; $display("FAIL txen_bdone got %0d expected 1", nbd - n0); end
        vectors++; if (bcnt_a !== 16'd37) begin miscompares++; $display("FAIL txen_bcnt got %0d expected 37", bcnt_a); end
        vectors++; if (fq.size() != 1) begin miscompares++; $display("FAIL txen_fifo got %0d left expected 1", fq.size()); end
    endtask

    task automatic test_reset_mid_byte;
        int w;
        push_a(8'hA5);
        tx_en_a = 1'b1;
        wait_rdreq(1'b0, 5, w);
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL rst_fetch got %0d expected 1", w); end
        repeat (56) @(negedge clk);
        vectors++; if (txd_a !== 1'b0) begin miscompares++; $display("FAIL rst_bit4 got %b expected 0", txd_a); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (txd_a !== 1'b1) begin miscompares++; $display("FAIL rst_async_txd got %b expected 1", txd_a); end
        vectors++; if (st_a !== 3'd0) begin miscompares++; $display("FAIL rst_async_state got %0d expected 0", st_a); end
        vectors++; if ({busy_a, bcnt_a, fcnt_a} !== 25'd0) begin miscompares++; $display("FAIL rst_async_cnt got busy %b bcnt %0d fcnt %0d expected 0", busy_a, bcnt_a, fcnt_a); end
        repeat (3) @(negedge clk);
        rxq.delete();
        rdq_t.delete();
        reset_n = 1'b1;
        wait_rdreq(1'b0, 5, w);
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL rst_refetch got %0d expected 1", w); end
        repeat (110) @(negedge clk);
        vectors++; if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin miscompares++; $display("FAIL rst_rx got %0d bytes expected one a5", rxq.size()); end
        vectors++; if (bcnt_a !== 16'd1) begin miscompares++; $display("FAIL rst_bcnt got %0d expected 1", bcnt_a); end
        vectors++; if (fq.size() != 0) begin miscompares++; $display("FAIL rst_fifo got %0d left expected 0", fq.size()); end
    endtask

    task automatic test_stop2_wrap;
        logic [7:0]  bytes[2];
        logic [15:0] mb;
        logic [7:0]  mf;
        logic [4:0]  got, exp;
        int w;
        bit eof;
        bytes[0] = 8'hFF;
        bytes[1] = 8'h0A;
        @(negedge clk);
        force dut_b.byte_cnt_q = 16'hFFFF;
        force dut_b.frame_cnt_q = 8'hFF;
        repeat (2) @(negedge clk);
        release dut_b.byte_cnt_q;
        release dut_b.frame_cnt_q;
        mb = 16'hFFFF;
        mf = 8'hFF;
        for (int n = 0; n < 2; n++) begin
            fifo_q_b = bytes[n];
            fifo_empty_b = 1'b0;
            wait_rdreq(1'b1, 5, w);
            vectors++; if (w !== 1) begin miscompares++; $display("FAIL b_fetch n=%0d got %0d expected 1", n, w); end
            if (w < 0) return;
            fifo_empty_b = 1'b1;
            eof = (bytes[n] == 8'h0A);
            for (int k = 0; k < 2 + 11 * D + 1; k++) begin
                got = {txd_b, rdreq_b, busy_b, bdone_b, fdone_b};
                exp = {model_txd(k, bytes[n]), (k == 0), (k <= 2 + 11 * D - 1),
                       (k == 2 + 11 * D - 1), eof && (k == 2 + 11 * D - 1)};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL wave_b n=%0d k=%0d got txd/rdreq/busy/bdone/fdone=%b expected %b", n, k, got, exp);
                end
                @(negedge clk);
            end
            mb = mb + 16'd1;
            if (eof) mf = mf + 8'd1;
            vectors++; if (bcnt_b !== mb) begin miscompares++; $display("FAIL b_bcnt n=%0d got %h expected %h", n, bcnt_b, mb); end
            vectors++; if (fcnt_b !== mf) begin miscompares++; $display("FAIL b_fcnt n=%0d got %h expected %h", n, fcnt_b, mf); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_frame();
        test_tx_en();
        test_reset_mid_byte();
        test_stop2_wrap();
        vectors++; if (underflow != 0) begin miscompares++; $display("FAIL fifo_underflow got %0d expected 0", underflow); end
        vectors++; if (rx_ferr != 0) begin miscompares++; $display("FAIL stop_bit_errors got %0d expected 0", rx_ferr); end
        vectors++; if (coinc_err != 0) begin miscompares++; $display("FAIL frame_without_byte got %0d expected 0", coinc_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
Drains the 8-bit AD sample FIFO (normal-mode read, q valid one clock after rdreq) and sends each byte on a UART line as 8N1 (or 8N2), LSB first. It sits directly downstream of the polling controller's FIFO read port (rdreq/empty/q) and feeds the board's serial TX pin to the host PC. It counts transmitted bytes and completed frames; a frame ends with a transmitted EOF_BYTE (0x0A, the trailing LF of each scan).

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD, 115200, line rate; bit period DIV = CLK_FREQ/BAUD, integer truncation (434 at defaults), DIV >= 2 required
STOP_BITS, 1, number of stop bits; legal values 1 or 2
EOF_BYTE, 8'h0A, byte value whose transmission pulses frame_done

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous reset, active-low
tx_en  in  1  1 = allowed to fetch new bytes; sampled only in IDLE
fifo_empty  in  1  FIFO empty flag
fifo_q  in  8  FIFO read data, valid the clock after fifo_rdreq
fifo_rdreq  out  1  FIFO read request, one-clock pulse per byte
uart_txd  out  1  serial output; idle high
busy  out  1  1 whenever state != IDLE
byte_done  out  1  one-clock pulse at end of each stop period
frame_done  out  1  one-clock pulse, coincident with byte_done, when the sent byte == EOF_BYTE
byte_cnt  out  16  bytes sent since reset; wraps 0xFFFF->0
frame_cnt  out  8  frames sent since reset; wraps 0xFF->0
tx_state  out  3  current state encoding, debug

Behaviour:
- Reset (async, reset_n=0): state=IDLE, uart_txd=1, fifo_rdreq=0, busy=0, byte_done=0, frame_done=0, byte_cnt=0, frame_cnt=0, baud_cnt=0, bit_idx=0, shift register=0. Reset mid-byte aborts the byte; line returns high immediately. A byte already popped but not sent is lost.
- All outputs are registered.
- State encoding: IDLE=0, RD_REQ=1, RD_WAIT=2, START=3, DATA=4, STOP=5.
- IDLE: if tx_en=1 and fifo_empty=0 at a clock edge -> RD_REQ; otherwise stay. uart_txd=1.
- RD_REQ (1 clock): fifo_rdreq=1 for exactly this clock -> RD_WAIT.
- RD_WAIT (1 clock): at its closing edge, latch fifo_q into the shift register, clear baud_cnt -> START.
- START: uart_txd=0 for DIV clocks -> DATA with bit_idx=0.
- DATA: uart_txd=shift[bit_idx] for DIV clocks per bit, bits 0..7 in order. After bit 7 -> STOP.
- STOP: uart_txd=1 for DIV*STOP_BITS clocks. On the final clock:
  - byte_done=1 and byte_cnt+1.
  - If the latched byte == EOF_BYTE, also frame_done=1 and frame_cnt+1.
  - Next state: IDLE.
- baud_cnt runs 0..DIV-1 and resets on every bit boundary and state entry. Its width must hold DIV-1; 16 bits is sufficient.
- Timing:
  - rdreq latency: fifo_rdreq rises 1 clock after the IDLE edge that samples the fetch condition.
  - Start bit: uart_txd falls 2 clocks after fifo_rdreq rises.
  - Byte period: exactly (1+8+STOP_BITS)*DIV + 3 clocks, start of RD_REQ to start of the next RD_REQ.
- tx_en=0 while not IDLE: the current byte completes normally; no further fetch.
- fifo_empty is ignored outside IDLE. The block never issues rdreq when fifo_empty=1 was sampled, so no read underflow.
- fifo_q is don't-care except in RD_WAIT.
- busy is high from the RD_REQ entry through the last STOP clock.

Test Plan:
- Reset values (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10): hold reset_n=0 -> uart_txd=1, busy=0, fifo_rdreq=0, byte_cnt=0, frame_cnt=0.
- Single byte 0x5A, tx_en=1, fifo_empty falls -> one fifo_rdreq pulse; 2 clocks later 10 clocks low. Then bits 0,1,0,1,1,0,1,0 at 10 clocks each, then 10 clocks high. byte_done pulses once, byte_cnt=1, frame_done stays 0.
- Frame of 32 samples + 0xCC, 0x0D, 0x0A queued -> 35 rdreq pulses with 103 clocks between successive pulses. frame_done pulses once, on the 0x0A stop, and byte_cnt=35, frame_cnt=1.
- tx_en=0 with FIFO non-empty -> no rdreq, txd stays 1. Drop tx_en during DATA of byte 0x81 -> the byte completes and no second rdreq is issued.
- Assert reset_n=0 during DATA bit 4 -> uart_txd=1 asynchronously and state=IDLE. After release with the FIFO non-empty, the next byte transmits cleanly.
- STOP_BITS=2, byte 0xFF -> stop high for 20 clocks before byte_done. byte_cnt preset to 0xFFFF wraps to 0 and frame_cnt 0xFF wraps to 0 on a 0x0A.
